// File: rtl/templatized_alu_sequencer.sv
// templatized_alu_sequencer: runs one op at a time across three ALU units.
// It decodes the op_code into a unit-enable mask, pulses start to the enabled
// units and collects their done/result. It then returns a single response beat.
module templatized_alu_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op_code,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2:0]         unit_start,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  input  logic [2:0]         unit_done,
  input  logic [3*WIDTH-1:0] unit_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [1:0]         out_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [1:0]       ERR_OK      = 2'b00;
  localparam logic [1:0]       ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

  state_t                  state_q, state_d;
  logic [2:0]              en_q, en_d;
  logic [2:0]              done_q, done_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic [1:0]              err_q, err_d;
  logic [2:0][WIDTH-1:0]   cap_q, cap_d;
  logic [2:0]              en_dec;
  logic [2:0]              first_done;
  logic [WIDTH-1:0]        final_result;

  // op_code to unit-enable mask; a zero mask marks an illegal code
  always_comb begin
    en_dec = 3'b000;
    case (in_op_code)
      4'b0000, 4'b0001, 4'b0010:          en_dec = 3'b100;
      4'b0100:                            en_dec = 3'b110;
      4'b0101:                            en_dec = 3'b010;
      4'b0110, 4'b0111, 4'b1000, 4'b1001: en_dec = 3'b001;
      default:                            en_dec = 3'b000;
    endcase
  end

  // Per-unit result capture: a unit's result is taken only on the first WAIT
  // cycle its done is seen, so a unit that keeps done high cannot overwrite it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_unit
    assign first_done[gi] = (state_q == S_WAIT) && unit_done[gi] && en_q[gi] && !done_q[gi];
    assign cap_d[gi]      = first_done[gi] ? unit_result[gi*WIDTH +: WIDTH] : cap_q[gi];
  end

  // Multi-unit ops report the highest-index enabled unit
  always_comb begin
    final_result = cap_d[0];
    if (en_q[2])      final_result = cap_d[2];
    else if (en_q[1]) final_result = cap_d[1];
  end

  // Next-state and datapath updates for the sequencer FSM
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          en_d = en_dec;
          a_d  = in_a;
          b_d  = in_b;
          if (en_dec != 3'b000) begin
            state_d = S_ISSUE;
          end else begin
            state_d  = S_RESP;
            err_d    = ERR_ILLEGAL;
            result_d = '0;
          end
        end
      end
      S_ISSUE: begin
        done_d  = 3'b000;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_d = done_q | (unit_done & en_q);
        // Saturating WAIT-cycle counter; the FSM leaves WAIT when it hits TIMEOUT
        if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + 1'b1;
        if (done_d == en_q) begin
          state_d  = S_RESP;
          err_d    = ERR_OK;
          result_d = final_result;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d  = S_RESP;
          err_d    = ERR_TIMEOUT;
          result_d = '0;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= 3'b000;
      done_q   <= 3'b000;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign unit_start = (state_q == S_ISSUE) ? en_q : 3'b000;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule
